dtw_scheduler: RTL and testbench
================================

# dtw_scheduler

Time-multiplexes one `dtw` engine across `N_JOINTS` pose channels. Holds a reference-trajectory memory loaded by the host and buffers one camera window of `SIZE` frames. Runs the engine once per joint, serving its `ready_refer`/`ready_camera` pulls from the buffers. Emits per-joint scores, a summed total and a pass/fail verdict against a programmable threshold.

## Interface
- `DATA_WIDTH`, 10: sample and score width (matches engine)
- `SIZE`, 20: samples per trajectory per joint
- `N_JOINTS`, 4: channels sharing the engine
- `TIMEOUT`, 4096: max cycles per engine run before abort
- `clk` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `ref_wr_en` in 1: reference write strobe; honoured only in IDLE
- `ref_wr_addr` in clog2(N_JOINTS*SIZE): address = joint*SIZE + t
- `ref_wr_data` in DATA_WIDTH: reference sample
- `start` in 1: begin a window; honoured only in IDLE
- `threshold` in DATA_WIDTH+clog2(N_JOINTS): pass limit, sampled at `start`
- `cam_valid` in 1 / `cam_data` in DATA_WIDTH / `cam_ready` out 1: camera stream, frame-major (t0 j0..jN-1, t1 j0..)
- `dtw_rst_n` out 1: engine reset
- `dtw_go` out 1: drives engine `ready`
- `dtw_refer`, `dtw_camera` out DATA_WIDTH: engine sample inputs
- `dtw_ready_refer`, `dtw_ready_camera`, `dtw_done` in 1; `dtw_score` in DATA_WIDTH: engine outputs
- `busy` out 1: high outside IDLE
- `score_valid` out 1 / `score_joint` out clog2(N_JOINTS) / `score_data` out DATA_WIDTH: per-joint result
- `result_valid` out 1 / `total_score` out DATA_WIDTH+clog2(N_JOINTS) / `pass` out 1 / `timeout_err` out 1: window result

## Operation
- States: IDLE, LOAD, CLR, RUN, NEXT, FINISH.
- IDLE:
  - Reference writes land in ref memory.
  - `start` latches `threshold`, clears `total_score`, `timeout_err`, joint, write index and cam pointers, then goes to LOAD.
- LOAD:
  - `cam_ready`=1.
  - Each `cam_valid&&cam_ready` beat k writes cam memory at (k mod N_JOINTS)*SIZE + k/N_JOINTS.
  - After N_JOINTS*SIZE beats, go to CLR; `cam_ready` drops the same cycle the last beat is accepted.
- CLR:
  - `dtw_rst_n`=0 for exactly 2 cycles; `dtw_go`=0.
  - refer pointer rp=0, camera pointer cp=0, watchdog=0.
  - Then go to RUN.
- RUN:
  - `dtw_go`=1.
  - `dtw_camera` = cam[joint*SIZE+cp]; combinational, valid in the same cycle as `dtw_ready_camera`. cp increments on each edge where `dtw_ready_camera`=1.
  - `dtw_refer` = ref[joint*SIZE+rp]. rp increments on the edge where a one-cycle-delayed copy of `dtw_ready_refer` is 1, because the engine captures refer one cycle after its pull.
  - rp and cp saturate at SIZE-1.
  - On `dtw_done`: capture `dtw_score` and go to NEXT.
  - If the watchdog reaches TIMEOUT-1 first: captured score = all-ones, set `timeout_err` (sticky until next `start`), go to NEXT.
- NEXT:
  - `dtw_go`=0.
  - `score_valid`=1 for 1 cycle with `score_joint`=joint and `score_data`=captured score.
  - `total_score` += score; zero-extended, cannot overflow.
  - If joint==N_JOINTS-1, go to FINISH; else joint++ and go to CLR.
- FINISH:
  - `result_valid`=1 for 1 cycle; `pass` = (total_score <= threshold) && !timeout_err.
  - Then go to IDLE.
- Engine strobes outside RUN are ignored; pointers hold.
- `dtw_done` and the watchdog expiring in the same cycle: done wins, real score, no error.

## Timing
- Reset (`rst_n` low at an edge):
  - state=IDLE, `busy`=0, `cam_ready`=0, `dtw_go`=0, `dtw_rst_n`=0.
  - All valids=0, `total_score`=0, `pass`=0, `timeout_err`=0, pointers=0.
  - `dtw_rst_n` returns to 1 on the first cycle after reset is released.
- Mid-operation reset: abort immediately, no `score_valid`/`result_valid`, memories not cleared.
- `start` to first `cam_ready`: 1 cycle.
- Last camera beat to first `dtw_go`: 3 cycles (2 in CLR, then RUN).
- `dtw_done` to `score_valid`: 1 cycle. Last `score_valid` to `result_valid`: 1 cycle.
- `start` while busy: ignored. `ref_wr_en` while busy: ignored.
- `cam_valid` stalls in LOAD: the FSM waits indefinitely, no timeout.
- All outputs are registered except `dtw_refer`/`dtw_camera`, which are memory reads.

## Test plan
- Reset mid-RUN:
  - Stimulus: assert `rst_n` low during joint 2.
  - Response: next cycle `busy`=0, `dtw_go`=0; no `result_valid`; a following full window completes normally.
- Identical trajectories:
  - Stimulus: N_JOINTS=4, SIZE=20, reference = camera = ramp 0..19 per joint, behavioural DTW model.
  - Response: four `score_valid` with joints 0..3 and score 0; `total_score`=0, `pass`=1.
- Offset trajectories:
  - Stimulus: camera = reference+3 on joint 1 only; threshold=59.
  - Response: joint 1 score = model value; pass iff total ≤ 59; other scores 0.
- Watchdog:
  - Stimulus: engine stub never asserts `dtw_done`, TIMEOUT=64.
  - Response: each joint reports 0x3FF after 64 RUN cycles; `timeout_err`=1, `pass`=0, total=4*1023.
- Handshake alignment:
  - Stimulus: stub checks that the refer value 1 cycle after each `ready_refer` equals ref[t], and the camera value during `ready_camera` equals cam[t].
  - Response: no mismatches; 21+ pulls hold at sample 19.
- Protocol robustness:
  - Stimulus: random `cam_valid` gaps; `start` and `ref_wr_en` pulsed during LOAD; `dtw_done` coinciding with watchdog expiry.
  - Response: all ignored pulses ignored; the coincident case gives the real score with `timeout_err`=0.

Source files
------------

// File: rtl/dtw_scheduler.sv
// Shares one dtw engine across N_JOINTS pose channels: buffers reference and camera
// trajectories, runs the engine once per joint, then sums the scores into a pass/fail verdict.
module dtw_scheduler #(
  parameter int DATA_WIDTH = 10,
  parameter int SIZE       = 20,
  parameter int N_JOINTS   = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     ref_wr_en,
  input  logic [$clog2(N_JOINTS*SIZE)-1:0]         ref_wr_addr,
  input  logic [DATA_WIDTH-1:0]                    ref_wr_data,
  input  logic                                     start,
  input  logic [DATA_WIDTH+$clog2(N_JOINTS)-1:0]   threshold,
  input  logic                                     cam_valid,
  input  logic [DATA_WIDTH-1:0]                    cam_data,
  output logic                                     cam_ready,
  output logic                                     dtw_rst_n,
  output logic                                     dtw_go,
  output logic [DATA_WIDTH-1:0]                    dtw_refer,
  output logic [DATA_WIDTH-1:0]                    dtw_camera,
  input  logic                                     dtw_ready_refer,
  input  logic                                     dtw_ready_camera,
  input  logic                                     dtw_done,
  input  logic [DATA_WIDTH-1:0]                    dtw_score,
  output logic                                     busy,
  output logic                                     score_valid,
  output logic [$clog2(N_JOINTS)-1:0]              score_joint,
  output logic [DATA_WIDTH-1:0]                    score_data,
  output logic                                     result_valid,
  output logic [DATA_WIDTH+$clog2(N_JOINTS)-1:0]   total_score,
  output logic                                     pass,
  output logic                                     timeout_err
);

  // state  | meaning
  // IDLE   | host may write reference memory; waits for start
  // LOAD   | accepts one camera window, frame-major
  // CLR    | holds the engine in reset for two cycles, clears pointers
  // RUN    | engine active for the current joint, pulls served from memory
  // NEXT   | publishes the joint score and accumulates the total
  // FINISH | publishes the window verdict

  localparam int DEPTH = N_JOINTS * SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int JW    = $clog2(N_JOINTS);
  localparam int PW    = $clog2(SIZE);
  localparam int WW    = $clog2(TIMEOUT);
  localparam int TW    = DATA_WIDTH + JW;

  localparam logic [AW-1:0] SIZE_A     = AW'(SIZE);
  localparam logic [PW-1:0] T_LAST     = PW'(SIZE - 1);
  localparam logic [JW-1:0] J_LAST     = JW'(N_JOINTS - 1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_RUN, S_NEXT, S_FINISH
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  logic [DATA_WIDTH-1:0] cam_mem [DEPTH];

  logic [JW-1:0]         ld_j;
  logic [PW-1:0]         ld_t;
  logic [JW-1:0]         joint;
  logic [PW-1:0]         rp, cp;
  logic                  rr_d;
  logic [WW-1:0]         wdog;
  logic                  clr_cnt;
  logic [DATA_WIDTH-1:0] score_q;
  logic [TW-1:0]         thr_q;

  logic          beat, last_beat, wdog_exp;
  logic [AW-1:0] cam_wr_addr, rd_base;
  logic [TW-1:0] total_next;

  assign beat        = cam_valid && cam_ready;
  assign last_beat   = beat && (ld_j == J_LAST) && (ld_t == T_LAST);
  assign wdog_exp    = (wdog == WDOG_LAST);
  assign cam_wr_addr = AW'(ld_j) * SIZE_A + AW'(ld_t);
  assign rd_base     = AW'(joint) * SIZE_A;
  assign total_next  = total_score + TW'(score_q);
  assign score_data  = score_q;

  assign dtw_refer   = ref_mem[rd_base + AW'(rp)];
  assign dtw_camera  = cam_mem[rd_base + AW'(cp)];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start) next_state = S_LOAD;
      S_LOAD:   if (last_beat) next_state = S_CLR;
      S_CLR:    if (clr_cnt) next_state = S_RUN;
      S_RUN:    if (dtw_done || wdog_exp) next_state = S_NEXT;
      S_NEXT:   next_state = (joint == J_LAST) ? S_FINISH : S_CLR;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Memories keep their contents across reset; only the writes are gated.
  always_ff @(posedge clk) begin
    if (rst_n && ref_wr_en && state == S_IDLE) ref_mem[ref_wr_addr] <= ref_wr_data;
    if (rst_n && beat) cam_mem[cam_wr_addr] <= cam_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      cam_ready    <= 1'b0;
      dtw_go       <= 1'b0;
      dtw_rst_n    <= 1'b0;
      score_valid  <= 1'b0;
      score_joint  <= '0;
      score_q      <= '0;
      result_valid <= 1'b0;
      total_score  <= '0;
      pass         <= 1'b0;
      timeout_err  <= 1'b0;
      thr_q        <= '0;
      ld_j         <= '0;
      ld_t         <= '0;
      joint        <= '0;
      rp           <= '0;
      cp           <= '0;
      rr_d         <= 1'b0;
      wdog         <= '0;
      clr_cnt      <= 1'b0;
    end else begin
      busy         <= (next_state != S_IDLE);
      cam_ready    <= (next_state == S_LOAD);
      dtw_go       <= (next_state == S_RUN);
      dtw_rst_n    <= (next_state != S_CLR);
      score_valid  <= 1'b0;
      result_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            thr_q       <= threshold;
            total_score <= '0;
            timeout_err <= 1'b0;
            pass        <= 1'b0;
            joint       <= '0;
            ld_j        <= '0;
            ld_t        <= '0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (ld_j == J_LAST) begin
              ld_j <= '0;
              if (ld_t != T_LAST) ld_t <= ld_t + 1'b1;
            end else begin
              ld_j <= ld_j + 1'b1;
            end
          end
        end
        S_CLR: begin
          clr_cnt <= ~clr_cnt;
          rp      <= '0;
          cp      <= '0;
          rr_d    <= 1'b0;
          wdog    <= '0;
        end
        S_RUN: begin
          // The engine latches refer one cycle after its pull, so rp follows a delayed strobe.
          rr_d <= dtw_ready_refer;
          wdog <= wdog + 1'b1;
          if (dtw_ready_camera && cp != T_LAST) cp <= cp + 1'b1;
          if (rr_d && rp != T_LAST) rp <= rp + 1'b1;
          if (dtw_done) begin
            score_q     <= dtw_score;
            score_valid <= 1'b1;
            score_joint <= joint;
          end else if (wdog_exp) begin
            score_q     <= '1;
            timeout_err <= 1'b1;
            score_valid <= 1'b1;
            score_joint <= joint;
          end
        end
        S_NEXT: begin
          total_score <= total_next;
          if (joint == J_LAST) begin
            result_valid <= 1'b1;
            pass         <= (total_next <= thr_q) && !timeout_err;
          end else begin
            joint <= joint + 1'b1;
          end
        end
        S_FINISH: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_scheduler.sv
// Self-checking bench for dtw_scheduler: behavioural engine stub with a DTW model,
// scoreboard queues filled at window start and drained on score_valid/result_valid.
module tb_dtw_scheduler;
  localparam int DW = 10, SIZE = 20, NJ = 4, TO = 64;
  localparam int AW = 7, JW = 2, TW = 12;
  localparam int PULLS = 22, DONE_AT = 23;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          ref_wr_en = 1'b0;
  logic [AW-1:0] ref_wr_addr = '0;
  logic [DW-1:0] ref_wr_data = '0;
  logic          start = 1'b0;
  logic [TW-1:0] threshold = '0;
  logic          cam_valid = 1'b0;
  logic [DW-1:0] cam_data = '0;
  logic          cam_ready, dtw_rst_n, dtw_go;
  logic [DW-1:0] dtw_refer, dtw_camera;
  logic          dtw_ready_refer, dtw_ready_camera, dtw_done;
  logic [DW-1:0] dtw_score;
  logic          busy, score_valid, result_valid, pass, timeout_err;
  logic [JW-1:0] score_joint;
  logic [DW-1:0] score_data;
  logic [TW-1:0] total_score;

  dtw_scheduler #(.DATA_WIDTH(DW), .SIZE(SIZE), .N_JOINTS(NJ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_data(ref_wr_data),
    .start(start), .threshold(threshold),
    .cam_valid(cam_valid), .cam_data(cam_data), .cam_ready(cam_ready),
    .dtw_rst_n(dtw_rst_n), .dtw_go(dtw_go), .dtw_refer(dtw_refer), .dtw_camera(dtw_camera),
    .dtw_ready_refer(dtw_ready_refer), .dtw_ready_camera(dtw_ready_camera),
    .dtw_done(dtw_done), .dtw_score(dtw_score),
    .busy(busy), .score_valid(score_valid), .score_joint(score_joint), .score_data(score_data),
    .result_valid(result_valid), .total_score(total_score), .pass(pass), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int ref_m [NJ][SIZE];
  int cam_m [NJ][SIZE];

  function automatic int dtw_model(input int j);
    int d [SIZE][SIZE];
    int best, c;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) begin
        c = ref_m[j][i] - cam_m[j][k];
        if (c < 0) c = -c;
        if (i == 0 && k == 0) best = 0;
        else if (i == 0) best = d[i][k-1];
        else if (k == 0) best = d[i-1][k];
        else begin
          best = d[i-1][k-1];
          if (d[i-1][k] < best) best = d[i-1][k];
          if (d[i][k-1] < best) best = d[i][k-1];
        end
        d[i][k] = best + c;
      end
    end
    return (d[SIZE-1][SIZE-1] > 1023) ? 1023 : d[SIZE-1][SIZE-1];
  endfunction

  typedef struct { int joint; int score; int len; } sc_t;
  typedef struct { int total; int pass; int terr; } res_t;
  sc_t  exp_sq[$];
  res_t exp_rq[$];

  // Engine stub: mode 0 = done after its pulls, 1 = never done, 2 = done on the watchdog's last cycle.
  int eng_mode = 0, run_idx = 0, e_cyc = 0, last_len = 0, results_seen = 0;

  initial begin : engine
    int c, ix;
    logic prev_rr;
    dtw_ready_refer = 1'b0; dtw_ready_camera = 1'b0; dtw_done = 1'b0; dtw_score = '0;
    forever begin
      @(posedge clk); #1;
      if (dtw_go) begin
        c  = e_cyc;
        ix = (run_idx < NJ) ? run_idx : NJ - 1;
        prev_rr = dtw_ready_refer;
        dtw_ready_refer  = (c < PULLS);
        dtw_ready_camera = (c < PULLS);
        dtw_done = (eng_mode == 0 && c == DONE_AT) || (eng_mode == 2 && c == TO - 1);
        if (c == 0) dtw_score = DW'(dtw_model(ix));
        e_cyc++;
        @(negedge clk);
        if (dtw_ready_camera)
          check("cam_pull", 32'(dtw_camera), cam_m[ix][(c < SIZE) ? c : SIZE-1]);
        if (prev_rr)
          check("ref_pull", 32'(dtw_refer), ref_m[ix][(c-1 < SIZE) ? c-1 : SIZE-1]);
      end else begin
        dtw_ready_refer = 1'b0; dtw_ready_camera = 1'b0; dtw_done = 1'b0;
        if (e_cyc != 0) begin
          last_len = e_cyc;
          run_idx++;
          e_cyc = 0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (score_valid) begin
        if (exp_sq.size() == 0) check("unexp_score", 32'(score_valid), 0);
        else begin
          sc_t e;
          e = exp_sq.pop_front();
          check("score_joint", 32'(score_joint), e.joint);
          check("score_data", 32'(score_data), e.score);
          check("run_len", last_len, e.len);
        end
      end
      if (result_valid) begin
        results_seen++;
        if (exp_rq.size() == 0) check("unexp_result", 32'(result_valid), 0);
        else begin
          res_t r;
          r = exp_rq.pop_front();
          check("total_score", 32'(total_score), r.total);
          check("pass", 32'(pass), r.pass);
          check("timeout_err", 32'(timeout_err), r.terr);
        end
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_window(input int thr, input int mode, input bit gaps, input bit disturb);
    int tot, sc, terr;
    tot = 0;
    terr = (mode == 1) ? 1 : 0;
    for (int j = 0; j < NJ; j++) begin
      sc = (mode == 1) ? 1023 : dtw_model(j);
      exp_sq.push_back('{j, sc, (mode == 0) ? DONE_AT + 1 : TO});
      tot += sc;
    end
    exp_rq.push_back('{tot, (tot <= thr && terr == 0) ? 1 : 0, terr});
    eng_mode = mode;
    run_idx  = 0;
    start = 1'b1; threshold = TW'(thr);
    tick;
    start = 1'b0;
    check("start_to_ready", 32'(cam_ready), 1);
    check("busy_load", 32'(busy), 1);
    for (int t = 0; t < SIZE; t++) begin
      for (int j = 0; j < NJ; j++) begin
        if (gaps) repeat ($urandom_range(0, 2)) tick;
        cam_valid = 1'b1; cam_data = DW'(cam_m[j][t]);
        if (disturb && t == 10 && j == 0) begin
          start = 1'b1; threshold = '0;
          ref_wr_en = 1'b1; ref_wr_addr = '0; ref_wr_data = 10'h3ff;
        end
        tick;
        cam_valid = 1'b0; start = 1'b0; ref_wr_en = 1'b0;
      end
    end
    check("ready_drop", 32'(cam_ready), 0);
    check("clr1_rst", 32'(dtw_rst_n), 0);
    check("clr1_go", 32'(dtw_go), 0);
    tick;
    check("clr2_rst", 32'(dtw_rst_n), 0);
    check("clr2_go", 32'(dtw_go), 0);
    tick;
    check("beat_to_go", 32'(dtw_go), 1);
    check("run_rst", 32'(dtw_rst_n), 1);
  endtask

  task automatic wait_result();
    int seen0, n;
    seen0 = results_seen;
    n = 0;
    while (results_seen == seen0 && n < 3000) begin
      tick;
      n++;
    end
    check("result_seen", 32'(results_seen != seen0), 1);
    tick;
  endtask

  initial begin : main
    int n;
    for (int j = 0; j < NJ; j++)
      for (int t = 0; t < SIZE; t++) begin
        ref_m[j][t] = t;
        cam_m[j][t] = t;
      end

    rst_n = 1'b0;
    repeat (3) tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_cam_ready", 32'(cam_ready), 0);
    check("rst_go", 32'(dtw_go), 0);
    check("rst_dtw_rst", 32'(dtw_rst_n), 0);
    check("rst_score_valid", 32'(score_valid), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_total", 32'(total_score), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_terr", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick;
    check("rst_release", 32'(dtw_rst_n), 1);

    for (int j = 0; j < NJ; j++)
      for (int t = 0; t < SIZE; t++) begin
        ref_wr_en = 1'b1; ref_wr_addr = AW'(j * SIZE + t); ref_wr_data = DW'(ref_m[j][t]);
        tick;
      end
    ref_wr_en = 1'b0;
    tick;

    start_window(0, 0, 1'b0, 1'b0);
    wait_result();

    for (int t = 0; t < SIZE; t++) cam_m[1][t] = t + 3;
    start_window(59, 0, 1'b1, 1'b1);
    wait_result();
    start_window(12, 0, 1'b0, 1'b0);
    wait_result();
    start_window(11, 0, 1'b0, 1'b0);
    wait_result();

    start_window(4095, 1, 1'b0, 1'b0);
    wait_result();

    start_window(59, 2, 1'b0, 1'b0);
    wait_result();

    start_window(59, 0, 1'b0, 1'b0);
    n = 0;
    while (!(run_idx == 2 && dtw_go) && n < 2000) begin
      tick;
      n++;
    end
    check("reach_joint2", run_idx, 2);
    rst_n = 1'b0;
    exp_sq.delete();
    exp_rq.delete();
    tick;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_go", 32'(dtw_go), 0);
    check("midrst_dtw_rst", 32'(dtw_rst_n), 0);
    check("midrst_total", 32'(total_score), 0);
    rst_n = 1'b1;
    tick;
    check("midrst_release", 32'(dtw_rst_n), 1);
    repeat (150) tick;

    start_window(59, 0, 1'b1, 1'b0);
    wait_result();

    check("sb_empty", 32'(exp_sq.size() + exp_rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
